// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: instruction-memory req/ack bus between the fetch stage and memory.
interface if_fetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetches 32-bit words into a 16-bit parcel queue and reassembles
// compressed and 32-bit (possibly word-straddling) instructions into the IF/ID register.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      flush_pc,
   if_fetch_queue_if.master mem,
   output logic [31:0]      IF_ID_PC,
   output logic [31:0]      IF_ID_inst,
   output logic             IF_ID_valid
);
   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH + 1);
   localparam logic [31:0]   NOP     = 32'h0000_0013;
   localparam logic [PW:0]   DEPTH_W = DEPTH[PW:0];
   localparam logic [OW-1:0] REFILL  = OW'(DEPTH - 2);
   logic [15:0]   pq_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [OW-1:0] occ_q, occ_d;
   logic [31:0]   addr_q, addr_d, redir_q, redir_d, pc_q, pc_d;
   logic [31:0]   id_pc_q, id_pc_d, id_inst_q, id_inst_d;
   logic          req_q, req_d, drop_q, drop_d, stale_q, stale_d, id_valid_q, id_valid_d;
   logic [15:0]   head, nxt;
   logic [1:0]    push_n, pop_n;
   logic          xfer, pending, wide, avail, pop;
   function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input logic [1:0] k);
      logic [PW:0] s;
      s = {1'b0, p} + {{(PW - 1){1'b0}}, k};
      return s >= DEPTH_W ? PW'(s - DEPTH_W) : s[PW-1:0];
   endfunction
   always_comb begin
      head       = pq_q[rd_q];
      nxt        = pq_q[wrap(rd_q, 2'd1)];
      wide       = head[1:0] == 2'b11;
      avail      = occ_q >= (wide ? OW'(2) : OW'(1));
      xfer       = req_q & mem.imem_ack;
      pending    = req_q & ~mem.imem_ack;
      pop        = avail & ~stall & ~flush;
      push_n     = (xfer & ~stale_q & ~flush) ? (drop_q ? 2'd1 : 2'd2) : 2'd0;
      pop_n      = pop ? (wide ? 2'd2 : 2'd1) : 2'd0;
      occ_d      = flush ? '0 : occ_q + OW'(push_n) - OW'(pop_n);
      rd_d       = flush ? '0 : wrap(rd_q, pop_n);
      wr_d       = flush ? '0 : wrap(wr_q, push_n);
      // a flushed request must still be held until its ack; a fresh one waits a cycle
      req_d      = pending | (~flush & occ_d <= REFILL);
      stale_d    = flush ? pending : stale_q & ~xfer;
      redir_d    = flush ? flush_pc & ~32'd3 : redir_q;
      addr_d     = (flush & ~pending) ? flush_pc & ~32'd3 :
                   xfer ? (stale_q ? redir_q : addr_q + 32'd4) : addr_q;
      drop_d     = flush ? flush_pc[1] : drop_q & ~(push_n != 2'd0);
      pc_d       = flush ? flush_pc & ~32'd1 : pop ? pc_q + (wide ? 32'd4 : 32'd2) : pc_q;
      id_valid_d = ~flush & (stall ? id_valid_q : avail);
      id_inst_d  = flush ? NOP : stall ? id_inst_q :
                   avail ? (wide ? {nxt, head} : {16'h0, head}) : NOP;
      id_pc_d    = pop ? pc_q : id_pc_q;
   end
   always_ff @(posedge clk) begin
      if (push_n != 2'd0) pq_q[wr_q] <= drop_q ? mem.imem_rdata[31:16] : mem.imem_rdata[15:0];
      if (push_n == 2'd2) pq_q[wrap(wr_q, 2'd1)] <= mem.imem_rdata[31:16];
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q       <= '0;
         wr_q       <= '0;
         occ_q      <= '0;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC & ~32'd3;
         redir_q    <= RESET_PC & ~32'd3;
         pc_q       <= RESET_PC & ~32'd1;
         drop_q     <= RESET_PC[1];
         stale_q    <= 1'b0;
         id_pc_q    <= '0;
         id_inst_q  <= NOP;
         id_valid_q <= 1'b0;
      end else begin
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         occ_q      <= occ_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         redir_q    <= redir_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         stale_q    <= stale_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
         id_valid_q <= id_valid_d;
      end
   end
   assign mem.imem_req  = req_q;
   assign mem.imem_addr = addr_q;
   assign IF_ID_PC      = id_pc_q;
   assign IF_ID_inst    = id_inst_q;
   assign IF_ID_valid   = id_valid_q;
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed and randomized checks of the fetch queue against an
// instruction-stream model that decodes parcels straight from the memory image.
module tb_if_fetch_queue;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic [31:0] IF_ID_PC, IF_ID_inst;
   logic        IF_ID_valid;
   logic [31:0] mem_w [256];
   int          lat = 0, cnt = 0, checks = 0, errors = 0, nvalid = 0;
   logic [31:0] exp_pc = '0, pp = '0, pi = '0, prev_addr = '0;
   logic        pv = 1'b0, prev_req = 1'b0;

   if_fetch_queue_if m ();

   if_fetch_queue #(.RESET_PC(32'h0), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
      .mem(m), .IF_ID_PC(IF_ID_PC), .IF_ID_inst(IF_ID_inst), .IF_ID_valid(IF_ID_valid));

   always #5 clk = ~clk;

   // memory: acks after lat waiting cycles, data valid alongside ack
   always @(negedge clk) begin
      if (m.imem_ack) cnt = 0;
      if (m.imem_req && cnt >= lat) begin
         m.imem_ack   = 1'b1;
         m.imem_rdata = mem_w[m.imem_addr[9:2]];
      end else begin
         m.imem_ack   = 1'b0;
         m.imem_rdata = $urandom;
         if (m.imem_req) cnt++;
      end
   end

   function automatic logic [15:0] parcel(input logic [31:0] a);
      logic [31:0] w;
      w = mem_w[a[9:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   function automatic logic [31:0] inst_at(input logic [31:0] pc);
      logic [15:0] h;
      h = parcel(pc);
      return (h[1:0] == 2'b11) ? {parcel(pc + 32'd2), h} : {16'h0, h};
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      pv = IF_ID_valid; pi = IF_ID_inst; pp = IF_ID_PC;
      prev_req = m.imem_req; prev_addr = m.imem_addr;
   endtask

   // compares what the edge just produced with the instruction stream model
   task automatic obs(input logic st, input logic fl);
      if (prev_req && !m.imem_ack) begin
         chk("hold_req", m.imem_req, 1);
         chk("hold_addr", m.imem_addr, prev_addr);
      end
      if (fl) begin
         chk("flush_valid", IF_ID_valid, 0);
         chk("flush_inst", IF_ID_inst, NOP);
         exp_pc = flush_pc & ~32'd1;
      end else if (st) begin
         chk("stall_valid", IF_ID_valid, pv);
         chk("stall_inst", IF_ID_inst, pi);
         chk("stall_pc", IF_ID_PC, pp);
      end else if (IF_ID_valid) begin
         chk("pc", IF_ID_PC, exp_pc);
         chk("inst", IF_ID_inst, inst_at(exp_pc));
         exp_pc = exp_pc + ((parcel(exp_pc) & 16'h3) == 16'h3 ? 32'd4 : 32'd2);
         nvalid++;
      end else begin
         chk("bubble_inst", IF_ID_inst, NOP);
         chk("bubble_pc", IF_ID_PC, pp);
      end
      snap();
   endtask

   task automatic cyc(input logic st, input logic fl);
      stall = st; flush = fl;
      tick();
      obs(st, fl);
      stall = 1'b0; flush = 1'b0;
   endtask

   // asserts reset between edges and checks it acts immediately
   task automatic do_reset();
      stall = 1'b0; flush = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rst_req", m.imem_req, 0);
      chk("rst_valid", IF_ID_valid, 0);
      chk("rst_inst", IF_ID_inst, NOP);
      chk("rst_pc", IF_ID_PC, 0);
      chk("rst_addr", m.imem_addr, 0);
      tick(); tick();
      rst = 1'b1;
      exp_pc = 32'h0;
      snap();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_w[i] = $urandom;
      tick();
      // zero-wait latency and back-to-back 32-bit instructions
      mem_w[0] = 32'h00A0_0093;
      mem_w[1] = 32'h00B0_0113;
      for (int i = 2; i < 8; i++) mem_w[i] = NOP;
      do_reset();
      cyc(0, 0);
      chk("t1_e1_req", m.imem_req, 1);
      chk("t1_e1_valid", IF_ID_valid, 0);
      cyc(0, 0);
      chk("t1_e2_valid", IF_ID_valid, 0);
      cyc(0, 0);
      chk("t1_e3_valid", IF_ID_valid, 1);
      chk("t1_e3_pc", IF_ID_PC, 32'h0);
      chk("t1_e3_inst", IF_ID_inst, 32'h00A0_0093);
      cyc(0, 0);
      chk("t1_e4_pc", IF_ID_PC, 32'h4);
      chk("t1_e4_inst", IF_ID_inst, 32'h00B0_0113);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0);
         chk("t1_no_bubble", IF_ID_valid, 1);
      end
      // compressed and word-straddling instructions
      mem_w[0] = 32'h0093_4501;
      mem_w[1] = 32'h0001_00A0;
      for (int i = 2; i < 8; i++) mem_w[i] = $urandom;
      do_reset();
      cyc(0, 0); cyc(0, 0); cyc(0, 0);
      chk("t2_pc0", IF_ID_PC, 32'h0);
      chk("t2_inst0", IF_ID_inst, 32'h0000_4501);
      cyc(0, 0);
      chk("t2_pc2", IF_ID_PC, 32'h2);
      chk("t2_inst2", IF_ID_inst, 32'h00A0_0093);
      cyc(0, 0);
      chk("t2_pc6", IF_ID_PC, 32'h6);
      chk("t2_inst6", IF_ID_inst, 32'h0000_0001);
      // slow memory with a long stall: queue fills, requests stop
      lat = 3;
      do_reset();
      for (int i = 0; i < 40 && !IF_ID_valid; i++) cyc(0, 0);
      chk("t3_started", IF_ID_valid, 1);
      for (int i = 0; i < 12; i++) begin
         cyc(1, 0);
         if (i >= 10) chk("t3_full_noreq", m.imem_req, 0);
      end
      for (int i = 0; i < 30; i++) cyc(0, 0);
      // flush to 0x102 while the request to 0x8 is still waiting
      do_reset();
      for (int i = 0; i < 40 && !(m.imem_req && m.imem_addr == 32'h8); i++) cyc(0, 0);
      chk("t4_req8", m.imem_addr, 32'h8);
      flush_pc = 32'h102;
      cyc(0, 1);
      for (int i = 0; i < 20 && m.imem_addr == 32'h8; i++) cyc(0, 0);
      chk("t4_redirect_addr", m.imem_addr, 32'h100);
      chk("t4_redirect_req", m.imem_req, 1);
      for (int i = 0; i < 20 && !IF_ID_valid; i++) cyc(0, 0);
      chk("t4_first_valid", IF_ID_valid, 1);
      chk("t4_first_pc", IF_ID_PC, 32'h102);
      // flush and stall together, zero-wait latency of the redirect
      lat = 0;
      for (int i = 0; i < 6; i++) cyc(0, 0);
      flush_pc = 32'h40;
      cyc(1, 1);
      chk("t5_inst", IF_ID_inst, NOP);
      cyc(0, 0);
      chk("t5_e1_valid", IF_ID_valid, 0);
      cyc(0, 0);
      chk("t5_e2_valid", IF_ID_valid, 0);
      cyc(0, 0);
      chk("t5_e3_valid", IF_ID_valid, 1);
      chk("t5_e3_pc", IF_ID_PC, 32'h40);
      // reset in the middle of a request
      lat = 3;
      for (int i = 0; i < 40 && !(IF_ID_valid && m.imem_req); i++) cyc(0, 0);
      chk("t6_busy", {31'b0, IF_ID_valid & m.imem_req}, 1);
      do_reset();
      for (int i = 0; i < 10 && !m.imem_req; i++) cyc(0, 0);
      chk("t6_restart_addr", m.imem_addr, 32'h0);
      for (int i = 0; i < 20 && !IF_ID_valid; i++) cyc(0, 0);
      chk("t6_restart_pc", IF_ID_PC, 32'h0);
      // randomized stalls, flushes and memory latency
      nvalid = 0;
      for (int s = 0; s < 8; s++) begin
         lat = $urandom_range(0, 3);
         for (int i = 0; i < 50; i++) begin
            flush_pc = $urandom_range(0, 1023);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
         end
      end
      chk("progress", {31'b0, nvalid >= 20}, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
